aes_key_expand_store: RTL and testbench

//  Sequential AES-128 key schedule for the decryption datapath. Accepts one 128-bit cipher key,

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_key_expand_store_if.sv | 21 ++
 rtl/aes_sbox.sv | 27 ++
 rtl/aes_key_expand_store.sv | 147 ++++++++++++++
 tb/tb_aes_key_expand_store.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and key-schedule constants.
// Used by the key-expansion store and its handshake interface.
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };
endpackage

// File: rtl/aes_key_expand_store_if.sv
// Cipher-key load handshake: key_in/key_valid in, key_ready out.
// master = key source, slave = key-expansion store.
interface aes_key_expand_store_if;
  import aes_pkg::*;

  blk_t key_in;
  logic key_valid;
  logic key_ready;

  modport master (
    output key_in,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_in,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, 256x8 combinational lookup.
// Ports: a = input byte, y = substituted byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

// File: rtl/aes_key_expand_store.sv
// AES-128 key schedule: one round key per clock into an 11x128 register file.
// Ports: clk, rst_n, kif (key handshake), rk0..rk10, keys_valid, busy.
module aes_key_expand_store
  import aes_pkg::*;
#(
  parameter int NR            = AES_NR,
  parameter bit CLEAR_ON_LOAD = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  aes_key_expand_store_if.slave kif,
  output blk_t rk0,
  output blk_t rk1,
  output blk_t rk2,
  output blk_t rk3,
  output blk_t rk4,
  output blk_t rk5,
  output blk_t rk6,
  output blk_t rk7,
  output blk_t rk8,
  output blk_t rk9,
  output blk_t rk10,
  output logic keys_valid,
  output logic busy
);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       kv_q, kv_d;
  logic       load, wr;
  blk_t       rk_q [0:AES_NR];

  blk_t       src, nxt;
  logic [7:0] rcon;
  word_t      w0, w1, w2, w3;
  word_t      rw, sw, t;
  word_t      n0, n1, n2, n3;
  logic       cnt_ok;

  assign cnt_ok = (cnt_q != 4'd0) && (cnt_q <= 4'(NR));

  // cnt selects rk[cnt-1] as the source and RCON[cnt]
  always_comb begin
    src  = '0;
    rcon = '0;
    for (int i = 1; i <= AES_NR; i++) begin
      if (cnt_q == 4'(i)) begin
        src  = rk_q[i-1];
        rcon = RCON[i];
      end
    end
  end

  assign {w0, w1, w2, w3} = src;
  assign rw = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .a (rw[8*g +: 8]),
      .y (sw[8*g +: 8])
    );
  end

  assign t   = sw ^ {rcon, 24'h0};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign nxt = {n0, n1, n2, n3};

  assign kif.key_ready = (state_q == ST_IDLE) ||
                         (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kv_d    = kv_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (kif.key_valid) begin
          load    = 1'b1;
          state_d = ST_EXPAND;
          cnt_d   = 4'd1;
          kv_d    = 1'b0;
        end
      end
      ST_EXPAND: begin
        if (cnt_ok) begin
          wr = 1'b1;
          if (cnt_q == 4'(NR)) begin
            state_d = ST_DONE;
            kv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          kv_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        kv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      if (load) begin
        rk_q[0] <= kif.key_in;
        if (CLEAR_ON_LOAD) begin
          for (int i = 1; i <= AES_NR; i++) rk_q[i] <= '0;
        end
      end
      for (int i = 1; i <= AES_NR; i++) begin
        if (wr && cnt_q == 4'(i)) rk_q[i] <= nxt;
      end
    end
  end

  assign keys_valid = kv_q;
  assign busy       = (state_q == ST_EXPAND);

  assign rk0  = rk_q[0];
  assign rk1  = rk_q[1];
  assign rk2  = rk_q[2];
  assign rk3  = rk_q[3];
  assign rk4  = rk_q[4];
  assign rk5  = rk_q[5];
  assign rk6  = rk_q[6];
  assign rk7  = rk_q[7];
  assign rk8  = rk_q[8];
  assign rk9  = rk_q[9];
  assign rk10 = rk_q[10];
endmodule

// File: tb/tb_aes_key_expand_store.sv
// Bench for aes_key_expand_store: directed steps, random keys,
// word-level FIPS-197 key schedule model with a GF(2^8)-derived S-box.
module tb_aes_key_expand_store;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  blk_t rk [0:10];
  logic keys_valid, busy;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] sb [0:255];
  blk_t       exp_rk [0:10];

  always #5 clk = ~clk;

  aes_key_expand_store_if kif ();

  aes_key_expand_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kif        (kif),
    .rk0        (rk[0]),
    .rk1        (rk[1]),
    .rk2        (rk[2]),
    .rk3        (rk[3]),
    .rk4        (rk[4]),
    .rk5        (rk[5]),
    .rk6        (rk[6]),
    .rk7        (rk[7]),
    .rk8        (rk[8]),
    .rk9        (rk[9]),
    .rk10       (rk[10]),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d;
    d = {v, v} << s;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
           rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model(input blk_t key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int r = 0; r < 11; r++)
      chk($sformatf("%s_rk%0d", tag, r), rk[r], exp_rk[r]);
  endtask

  function automatic blk_t rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one accept; returns #1 after edge E0
  task automatic accept(input blk_t key);
    kif.key_in    = key;
    kif.key_valid = 1'b1;
    tick();
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!keys_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
  endtask

  blk_t key1, key2, k, junk;
  int   inj_n;

  initial begin
    kif.key_in    = '0;
    kif.key_valid = 1'b0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));
    key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2 = 128'h000102030405060708090a0b0c0d0e0f;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk0", rk[0], 128'd0);
    chk("rst_rk10", rk[10], 128'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 128'(kif.key_ready), 128'd1);

    // key 1, with a foreign key pulsed in cycle 4 of EXPAND
    model(key1);
    accept(key1);
    chk("k1_e0_busy", 128'(busy), 128'd1);
    chk("k1_e0_ready", 128'(kif.key_ready), 128'd0);
    chk("k1_e0_rk0", rk[0], key1);
    junk = rnd_key();
    inj_n = 0;
    while (!keys_valid && inj_n < 20) begin
      if (inj_n == 3) begin
        kif.key_in    = junk;
        kif.key_valid = 1'b1;
        chk("k1_inj_ready", 128'(kif.key_ready), 128'd0);
      end
      tick();
      kif.key_valid = 1'b0;
      inj_n++;
    end
    chk("k1_latency", 128'(inj_n), 128'd10);
    chk("k1_busy_done", 128'(busy), 128'd0);
    chk("k1_rk1_vec", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("k1_rk10_vec", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk_all("k1");
    repeat (3) tick();
    chk("k1_hold_kv", 128'(keys_valid), 128'd1);
    chk("k1_hold_ready", 128'(kif.key_ready), 128'd1);
    chk_all("k1_hold");

    // key 2 loaded from DONE
    model(key2);
    accept(key2);
    chk("k2_e0_kv", 128'(keys_valid), 128'd0);
    chk("k2_e0_busy", 128'(busy), 128'd1);
    chk("k2_e0_rk0", rk[0], key2);
    chk("k2_e0_clr10", rk[10], 128'd0);
    wait_done("k2");
    chk("k2_rk10_vec", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk_all("k2");

    // asynchronous reset mid-expansion
    k = rnd_key();
    accept(k);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_kv", 128'(keys_valid), 128'd0);
    chk("ar_busy", 128'(busy), 128'd0);
    for (int r = 0; r < 11; r++)
      chk($sformatf("ar_rk%0d", r), rk[r], 128'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_ready", 128'(kif.key_ready), 128'd1);
    k = rnd_key();
    model(k);
    accept(k);
    wait_done("ar_reload");
    chk_all("ar_reload");

    // random keys
    for (int j = 0; j < 3; j++) begin
      k = rnd_key();
      model(k);
      accept(k);
      wait_done($sformatf("rnd%0d", j));
      chk_all($sformatf("rnd%0d", j));
    end

    // key_valid held high: accept, ignore, re-accept on first DONE cycle
    k = rnd_key();
    model(k);
    kif.key_in    = k;
    kif.key_valid = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      chk($sformatf("hold_kv_c%0d", c), 128'(keys_valid),
          128'((c % 11) == 0));
      if ((c % 11) == 0) begin
        chk($sformatf("hold_rk10_c%0d", c), rk[10], exp_rk[10]);
        chk($sformatf("hold_rk5_c%0d", c), rk[5], exp_rk[5]);
      end
    end
    kif.key_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
